strassen_mm2x2_seq: RTL
=======================

Name: strassen_mm2x2_seq

Overview:
- Parametrised, handshaked 2x2 matrix multiplier that computes C = A x B with Strassen's 7-product algorithm.
- Uses one shared multiplier and an internal FSM, and is the next generation of the fixed 32-bit, free-running multiplier array.
- Adds configurable operand width, a signed or unsigned mode, synchronous reset, valid/ready handshakes on both sides, and exact full-precision results.
- Sits between the operand fetch logic and the result store (C storage) in the datapath.

Parameters:
- WIDTH, 32, operand width in bits for every a and b element.
- SIGNED, 1, 1 = operands are two's complement; 0 = operands are unsigned.
- Local OUT_W = 2*WIDTH+1, the result width per C element. This holds any exact 2-term dot product in either mode.
- Local IW = 2*WIDTH+4, the signed internal accumulation width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept operands
- a11, a12, a21, a22  in  WIDTH each  matrix A
- b11, b12, b21, b22  in  WIDTH each  matrix B
- out_valid  out  1  C results valid
- out_ready  in  1  consumer accepts results
- c11, c12, c21, c22  out  OUT_W each  matrix C, registered
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset is synchronous and active-high, sampled at the rising edge of clk.
  - At reset: state=IDLE, product counter=0, out_valid=0, c11..c22=0, all internal m registers=0, busy=0.
  - in_ready is 0 in any cycle where reset=1.
- Handshakes:
  - Input accept occurs on an edge where in_valid & in_ready.
  - Output transfer occurs on an edge where out_valid & out_ready.
  - in_ready = (state==IDLE) & ~reset, combinational from state.
- FSM states: IDLE, MUL, COMB, DONE.
  - IDLE: wait for accept. On accept, register all 8 operands and form the pre-sums, then go to MUL with k=0.
  - Pre-sums are WIDTH+1 bits, sign-extended when SIGNED=1 and zero-extended when SIGNED=0:
    - a11+a22, a21+a22, a11+a12, a21-a11, a12-a22
    - b11+b22, b12-b22, b21-b11, b11+b12, b21+b22
  - Differences are always treated as signed internally, including when SIGNED=0.
  - MUL: one product per cycle, written to m(k+1); k increments 0..6. Products are 2*WIDTH+2 bits signed.
    - m1=(a11+a22)(b11+b22)
    - m2=(a21+a22)b11
    - m3=a11(b12-b22)
    - m4=a22(b21-b11)
    - m5=(a11+a12)b22
    - m6=(a21-a11)(b11+b12)
    - m7=(a12-a22)(b21+b22)
    - After k=6, go to COMB.
  - COMB: evaluate at IW bits, then truncate to OUT_W (the truncated value is exact). Set out_valid=1 and go to DONE.
    - c11=m1+m4-m5+m7
    - c12=m3+m5
    - c21=m2+m4
    - c22=m1-m2+m3+m6
  - DONE: hold c* and out_valid stable until out_ready. On the transfer edge, out_valid goes to 0 and the state goes to IDLE.
- Latency and throughput:
  - The accept edge is edge 0. MUL writes occur on edges 1..7, COMB on edge 8, and out_valid is high after edge 8.
  - With out_ready held high, the transfer happens on edge 9 and in_ready is high again after edge 9.
  - Minimum interval between accepts is 10 cycles; there is no overlap of jobs.
- Result hold: c* keep their last values after transfer and are not cleared. They change only at COMB or on reset.
- Don't-care inputs:
  - out_ready is ignored while out_valid=0.
  - in_valid is ignored while in_ready=0.
  - Operand inputs may change freely after the accept edge.
- Reset mid-operation (any state): the job is abandoned, the outputs are zeroed as at reset, and no out_valid is produced for the abandoned job.
- Simultaneous events: reset has priority over accept and over transfer on the same edge.

Test Plan:
- Basic multiply: WIDTH=32, SIGNED=1, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]]; out_valid rises exactly 8 edges after accept.
- Signed extremes: WIDTH=8, SIGNED=1, all a,b=-128 -> every c=32768; then A=[[-128,127],[0,-1]], B=[[127,-128],[-1,0]] -> c11=-16383, c12=16384, c21=1, c22=0.
- Unsigned maximum: WIDTH=8, SIGNED=0, all a,b=255 -> every c=130050 (17 bits); identity A with B=[[200,3],[0,255]] -> C=B.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> c*/out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> one transfer, in_ready=1 on the next cycle.
- Reset mid-job: reset asserted for 1 cycle during MUL k=3 -> out_valid never asserts for that job, c*=0, in_ready=1 the cycle after reset deasserts; a new job then completes correctly.
- Back-to-back streaming: in_valid and out_ready held high, 4 random jobs -> accepts 10 cycles apart, results match a reference multiply, each result presented exactly once.

Source files
------------

// File: rtl/strassen_mm2x2_seq.sv
// 2x2 matrix multiply C = A x B using Strassen's seven products, evaluated one per
// cycle on a single shared multiplier behind valid/ready handshakes.
module strassen_mm2x2_seq #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a11,
   input  logic [WIDTH-1:0]   a12,
   input  logic [WIDTH-1:0]   a21,
   input  logic [WIDTH-1:0]   a22,
   input  logic [WIDTH-1:0]   b11,
   input  logic [WIDTH-1:0]   b12,
   input  logic [WIDTH-1:0]   b21,
   input  logic [WIDTH-1:0]   b22,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH:0]   c11,
   output logic [2*WIDTH:0]   c12,
   output logic [2*WIDTH:0]   c21,
   output logic [2*WIDTH:0]   c22,
   output logic               busy
);
   localparam int OUT_W = 2*WIDTH + 1;
   localparam int IW    = 2*WIDTH + 4;
   localparam int PW    = WIDTH + 1;
   localparam int MW    = 2*WIDTH + 2;

   // Which per-product operands are differences: always sign-extended, even unsigned.
   localparam logic [6:0] A_DIFF = 7'b1100000;
   localparam logic [6:0] B_DIFF = 7'b0001100;

   typedef enum logic [1:0] {IDLE, MUL, COMB, DONE} state_t;

   state_t                r_state;
   logic [2:0]            r_k;
   logic [PW-1:0]         r_opa [7];
   logic [PW-1:0]         r_opb [7];
   logic signed [MW-1:0]  r_m [7];
   logic                  r_out_valid;
   logic [OUT_W-1:0]      r_c11, r_c12, r_c21, r_c22;

   logic                  w_accept;
   logic [PW-1:0]         w_a11, w_a12, w_a21, w_a22;
   logic [PW-1:0]         w_b11, w_b12, w_b21, w_b22;
   logic signed [PW:0]    w_mul_a, w_mul_b;
   logic signed [MW-1:0]  w_prod;

   function automatic logic [PW-1:0] ext_in(input logic [WIDTH-1:0] x);
      return SIGNED ? {x[WIDTH-1], x} : {1'b0, x};
   endfunction

   // Unsigned-mode sums are non-negative WIDTH+1 values; differences are signed.
   function automatic logic signed [PW:0] ext_op(input logic [PW-1:0] x, input logic is_diff);
      return (is_diff || SIGNED) ? {x[PW-1], x} : {1'b0, x};
   endfunction

   function automatic logic [OUT_W-1:0] fit_out(input logic signed [IW-1:0] x);
      return x[OUT_W-1:0];
   endfunction

   assign in_ready = (r_state == IDLE) && !reset;
   assign w_accept = in_valid && in_ready;

   assign w_a11 = ext_in(a11);
   assign w_a12 = ext_in(a12);
   assign w_a21 = ext_in(a21);
   assign w_a22 = ext_in(a22);
   assign w_b11 = ext_in(b11);
   assign w_b12 = ext_in(b12);
   assign w_b21 = ext_in(b21);
   assign w_b22 = ext_in(b22);

   assign w_mul_a = ext_op(r_opa[r_k], A_DIFF[r_k]);
   assign w_mul_b = ext_op(r_opb[r_k], B_DIFF[r_k]);
   assign w_prod  = MW'(w_mul_a) * MW'(w_mul_b);

   // Accept stage: capture operands and Strassen pre-sums, indexed by product number.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_opa[0] <= w_a11 + w_a22;
         r_opa[1] <= w_a21 + w_a22;
         r_opa[2] <= w_a11;
         r_opa[3] <= w_a22;
         r_opa[4] <= w_a11 + w_a12;
         r_opa[5] <= w_a21 - w_a11;
         r_opa[6] <= w_a12 - w_a22;
         r_opb[0] <= w_b11 + w_b22;
         r_opb[1] <= w_b11;
         r_opb[2] <= w_b12 - w_b22;
         r_opb[3] <= w_b21 - w_b11;
         r_opb[4] <= w_b22;
         r_opb[5] <= w_b11 + w_b12;
         r_opb[6] <= w_b21 + w_b22;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_out_valid <= 1'b0;
         r_c11       <= '0;
         r_c12       <= '0;
         r_c21       <= '0;
         r_c22       <= '0;
         for (int i = 0; i < 7; i++) r_m[i] <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_k     <= '0;
                  r_state <= MUL;
               end
            end
            MUL: begin
               r_m[r_k] <= w_prod;
               if (r_k == 3'd6) r_state <= COMB;
               else             r_k     <= r_k + 3'd1;
            end
            // Combine stage: exact at IW, so truncation to OUT_W loses nothing.
            COMB: begin
               r_c11       <= fit_out(IW'(r_m[0]) + IW'(r_m[3]) - IW'(r_m[4]) + IW'(r_m[6]));
               r_c12       <= fit_out(IW'(r_m[2]) + IW'(r_m[4]));
               r_c21       <= fit_out(IW'(r_m[1]) + IW'(r_m[3]));
               r_c22       <= fit_out(IW'(r_m[0]) - IW'(r_m[1]) + IW'(r_m[2]) + IW'(r_m[5]));
               r_out_valid <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign c11       = r_c11;
   assign c12       = r_c12;
   assign c21       = r_c21;
   assign c22       = r_c22;
   assign busy      = (r_state != IDLE);

endmodule
